// File: rtl/pokey_cell15_pkg.sv
// Shared types and the update-select helper for the POKEY storage cell.
`default_nettype none

package pokey_cell15_pkg;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_SHIFT = 2'd1,
    SEL_LOAD  = 2'd2
  } cell_sel_e;

  // Load outranks Shift; nothing moves outside an enable pulse.
  function automatic cell_sel_e cell_sel(input logic enp, input logic load, input logic shift);
    cell_sel_e sel;
    sel = SEL_HOLD;
    if (enp) begin
      if (load)       sel = SEL_LOAD;
      else if (shift) sel = SEL_SHIFT;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pokey_cell15.sv
// ============================================================================
//  Module   : pokey_cell15
//  Purpose  : Single-bit load/shift storage cell for POKEY shift and poly chains
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pokey_cell15
  import pokey_cell15_pkg::*;
#(
  parameter logic RESET_Q = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enp,
  input  logic Shift,
  input  logic Load,
  input  logic DIn,
  input  logic D,
  output logic Q
);

  cell_sel_e w_sel;
  logic      w_next;
  logic      r_q;

  always_comb begin
    w_sel  = cell_sel(enp, Load, Shift);
    w_next = r_q;
    case (w_sel)
      SEL_LOAD:  w_next = D;
      SEL_SHIFT: w_next = DIn;
      default:   w_next = r_q;
    endcase
  end

  // Registered output only, so a chain advances exactly one position per enp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RESET_Q;
    else        r_q <= w_next;
  end

  assign Q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_pokey_cell15.sv
// Self-checking bench for pokey_cell15: directed scenarios plus randomized traffic.
`default_nettype none

module tb_pokey_cell15;

  logic clk = 1'b0;
  logic rst_n, enp, Shift, Load, DIn, D, Q;

  int passed = 0;
  int total  = 0;

  pokey_cell15 #(.RESET_Q(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enp(enp), .Shift(Shift),
    .Load(Load), .DIn(DIn), .D(D), .Q(Q)
  );

  always #10 clk = ~clk;  // 50 MHz

  // 1.79 MHz machine clock (28 system clocks), 2-flop sync and rising-edge detect.
  int   slow_cnt = 0;
  logic slow_clk = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  always @(posedge clk) begin
    slow_cnt <= (slow_cnt == 27) ? 0 : slow_cnt + 1;
    slow_clk <= (slow_cnt < 14);
    s1 <= slow_clk;
    s2 <= s1;
    s3 <= s2;
  end
  assign enp = s2 & ~s3;

  // Reference: the bit the cell must hold, from the behavioural rules.
  logic exp_q = 1'b0;
  logic chk_en = 1'b0;
  always @(negedge rst_n) exp_q = 1'b0;
  always @(posedge clk) begin
    if (!rst_n)             exp_q = 1'b0;
    else if (enp && Load)   exp_q = D;
    else if (enp && Shift)  exp_q = DIn;
  end

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: Q=%b expected %b at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) if (chk_en) check("model", Q, exp_q);

  // Wait until the next enp pulse is consumed; returns on the negedge after it.
  task automatic wait_update();
    int n = 0;
    @(negedge clk);
    while (enp !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL enp_timeout: enp=%b expected 1", enp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; Shift = 1'b0; Load = 1'b0; DIn = 1'b1; D = 1'b0;

    // 1: reset dominates even with Load=1, D=1 and enp pulsing
    D = 1'b1; Load = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (70) @(negedge clk);
    check("reset_hold", Q, 1'b0);
    Load = 1'b0; D = 1'b0;
    rst_n = 1'b1;

    // 2: load 0
    Load = 1'b1; D = 1'b0;
    wait_update();
    check("load0", Q, 1'b0);
    Load = 1'b0;
    wait_update();
    check("load0_hold", Q, 1'b0);

    // 3: shift in 1
    DIn = 1'b1; Shift = 1'b1;
    wait_update();
    check("shift1", Q, 1'b1);
    Shift = 1'b0;
    wait_update();
    check("shift1_hold", Q, 1'b1);

    // 4: idle isolation, toggle D/DIn between pulses
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      D = ~D; DIn = ~DIn;
      wait_update();
    end
    check("idle_isolation", Q, 1'b1);

    // 5: shift selects DIn, not D
    D = 1'b1; DIn = 1'b0; Shift = 1'b1;
    wait_update();
    check("shift_ignores_d", Q, 1'b0);
    Shift = 1'b0;

    // 6: Load beats Shift
    Load = 1'b1; Shift = 1'b1; D = 1'b1; DIn = 0;
    wait_update();
    check("load_priority", Q, 1'b1);
    Load = 1'b0; Shift = 1'b0;

    // 7: Load pulse entirely between enp pulses
    wait_update();
    repeat (3) @(negedge clk);
    Load = 1'b1; D = 1'b0;
    repeat (5) @(negedge clk);
    Load = 1'b0; D = 1'b1;
    check("no_enp_load", Q, 1'b1);

    // Randomized traffic with occasional mid-cycle asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      Load  = ($urandom_range(0, 3) == 0);
      Shift = $urandom_range(0, 1);
      D     = $urandom_range(0, 1);
      DIn   = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        #1 check("async_reset", Q, 1'b0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Guarantee at least one mid-run reset with Q known to be 1
    @(negedge clk);
    Load = 1'b1; Shift = 1'b0; D = 1'b1;
    wait_update();
    check("preload1", Q, 1'b1);
    #3 rst_n = 1'b0;
    #1 check("async_reset_forced", Q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; Load = 1'b0;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
